// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, read-side FSM states and a
// sizing helper for register index buses.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } rd_state_t;

  // Width of a register index; a single-register window still gets one bit
  // so that index buses never collapse to zero width.
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decoder for an AXI4-Lite register window.
// Produces a hit flag (in range, word aligned, privilege satisfied) and the
// word index of the addressed register. Shared by the read and write paths.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter bit                    PRIV_ONLY  = 1'b0
) (
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [2:0]                     prot_i,
  output logic                           hit_o,
  output logic [idx_width(NUM_REGS)-1:0] idx_o
);

  localparam int                IDX_W        = idx_width(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] WINDOW_BYTES = (ADDR_WIDTH + 1)'(NUM_REGS * 4);

  logic [ADDR_WIDTH-1:0] offset;
  logic                  above_base;
  logic                  in_window;
  logic                  aligned;
  logic                  priv_ok;
  logic                  unused_prot;

  // Offset wraps for addresses below the base; above_base rejects those.
  assign offset      = addr_i - BASE_ADDR;
  assign above_base  = (addr_i >= BASE_ADDR);
  assign in_window   = ({1'b0, offset} < WINDOW_BYTES);
  assign aligned     = (addr_i[1:0] == 2'b00);
  // ARPROT[0] is the privileged bit; only it matters for access control here.
  assign priv_ok     = !PRIV_ONLY || prot_i[0];
  assign unused_prot = ^prot_i[2:1];

  assign hit_o = above_base && in_window && aligned && priv_ok;
  assign idx_o = offset[IDX_W+1:2];

endmodule

// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read responder. Accepts one read address at a time, fetches the
// word from a register file with a one-cycle read port and returns it on R.
// Rejected accesses answer SLVERR directly without touching the register file.
module axi_lite_read_slave
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter bit                    PRIV_ONLY  = 1'b0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           rf_rd_en,
  output logic [idx_width(NUM_REGS)-1:0] rf_rd_idx,
  input  logic [DATA_WIDTH-1:0]          rf_rd_data
);

  localparam int IDX_W = idx_width(NUM_REGS);

  rd_state_t             state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rf_rd_en_q;
  logic [IDX_W-1:0]      rf_rd_idx_q;

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic                  ar_hs;

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR),
    .PRIV_ONLY  (PRIV_ONLY)
  ) u_decode (
    .addr_i (ARADDR),
    .prot_i (ARPROT),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  // The decode result is consumed only on the AR handshake edge, so later
  // changes on ARADDR/ARPROT cannot affect an accepted transaction.
  assign ar_hs = ARVALID && arready_q;

  // Read FSM: every output is a register updated alongside the state.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rf_rd_en_q  <= 1'b0;
      rf_rd_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Also raises ARREADY on the first edge after reset release.
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            if (dec_hit) begin
              state_q     <= REQ;
              rf_rd_en_q  <= 1'b1;
              rf_rd_idx_q <= dec_idx;
            end else begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              rdata_q  <= '0;
              rresp_q  <= RESP_SLVERR;
            end
          end
        end
        REQ: begin
          // The strobe lasts exactly the one cycle spent in REQ.
          rf_rd_en_q <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // rf_rd_data now holds the word requested during REQ.
          rdata_q  <= rf_rd_data;
          rresp_q  <= RESP_OKAY;
          rvalid_q <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          if (RREADY) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            arready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b0;
          rdata_q    <= '0;
          rresp_q    <= RESP_OKAY;
          rf_rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign rf_rd_en  = rf_rd_en_q;
  assign rf_rd_idx = rf_rd_idx_q;

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Bench for axi_lite_read_slave. Three instances share clock and reset:
// 0 = defaults, 1 = PRIV_ONLY, 2 = BASE_ADDR 0x1000. A behavioural register
// file feeds each instance; expected responses come from address rules.
`timescale 1ns/1ps
module tb_axi_lite_read_slave;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        arvalid   [3];
  logic        arready   [3];
  logic [31:0] araddr    [3];
  logic [2:0]  arprot    [3];
  logic        rvalid    [3];
  logic        rready    [3];
  logic [31:0] rdata     [3];
  logic [1:0]  rresp     [3];
  logic        rf_en     [3];
  logic [3:0]  rf_idx    [3];
  logic [31:0] rf_data   [3];
  logic [31:0] regs      [16];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Observations from the most recent response collection.
  bit          ob_to;
  int          ob_lat, ob_en, ob_leak, ob_unstable, ob_arr_bad;
  logic [3:0]  ob_idx;
  logic [31:0] ob_data, ob_data_after;
  logic [1:0]  ob_resp, ob_resp_after;
  logic        ob_rv_after, ob_arr_after;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file with one-cycle read latency; garbage when not strobed.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      rf_data[i] <= rf_en[i] ? regs[rf_idx[i]] : $urandom;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      axi_lite_read_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .BASE_ADDR  ((gi == 2) ? 32'h0000_1000 : 32'h0000_0000),
        .PRIV_ONLY  (gi == 1)
      ) u_dut (
        .ACLK       (clk),
        .ARESETn    (aresetn),
        .ARVALID    (arvalid[gi]),
        .ARREADY    (arready[gi]),
        .ARADDR     (araddr[gi]),
        .ARPROT     (arprot[gi]),
        .RVALID     (rvalid[gi]),
        .RREADY     (rready[gi]),
        .RDATA      (rdata[gi]),
        .RRESP      (rresp[gi]),
        .rf_rd_en   (rf_en[gi]),
        .rf_rd_idx  (rf_idx[gi]),
        .rf_rd_data (rf_data[gi])
      );
    end
  endgenerate

  // Reference: what an access should return, from the address window rules.
  function automatic void model(input int s, input logic [31:0] addr, input logic [2:0] prot,
                                output logic [1:0] resp, output logic [31:0] data, output int lat);
    logic [31:0] base;
    logic [31:0] off;
    bit          good;
    base = (s == 2) ? 32'h1000 : 32'h0;
    off  = addr - base;
    good = (addr >= base) && (off < 32'd64) && (addr[1:0] == 2'b00) && !((s == 1) && !prot[0]);
    resp = good ? 2'b00 : 2'b10;
    data = good ? regs[off[5:2]] : 32'h0;
    lat  = good ? 3 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an address and wait (bounded) for the AR handshake edge.
  task automatic ar_send(input int s, input logic [31:0] a, input logic [2:0] p, output bit to);
    araddr[s]  = a;
    arprot[s]  = p;
    arvalid[s] = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (arready[s]) begin
        tick();
        to = 1'b0;
        break;
      end
      tick();
    end
    arvalid[s] = 1'b0;
    araddr[s]  = $urandom;
    arprot[s]  = 3'($urandom);
  endtask

  // Watch one response after a handshake; bp = cycles RREADY stays low.
  task automatic collect(input int s, input int bp);
    ob_to = 1'b1; ob_lat = 0; ob_en = 0; ob_leak = 0; ob_unstable = 0; ob_arr_bad = 0;
    ob_idx = '0; ob_data = '0; ob_resp = '0;
    ob_rv_after = 1'b1; ob_arr_after = 1'b0; ob_data_after = '1; ob_resp_after = '1;
    rready[s] = (bp == 0);
    for (int i = 1; i <= 12; i++) begin
      if (rf_en[s]) begin
        ob_en++;
        ob_idx = rf_idx[s];
      end
      if (arready[s]) ob_arr_bad++;
      if (rvalid[s]) begin
        ob_lat  = i;
        ob_data = rdata[s];
        ob_resp = rresp[s];
        ob_to   = 1'b0;
        break;
      end
      if (rdata[s] != 32'h0 || rresp[s] != 2'b00) ob_leak++;
      tick();
    end
    if (ob_to) begin
      rready[s] = 1'b0;
      return;
    end
    for (int j = 0; j < bp; j++) begin
      tick();
      if (!rvalid[s] || rdata[s] !== ob_data || rresp[s] !== ob_resp) ob_unstable++;
      if (arready[s]) ob_arr_bad++;
      if (rf_en[s]) ob_en++;
    end
    rready[s] = 1'b1;
    tick();
    ob_rv_after   = rvalid[s];
    ob_arr_after  = arready[s];
    ob_data_after = rdata[s];
    ob_resp_after = rresp[s];
    rready[s] = 1'b0;
    $display("txn dut=%0d lat=%0d resp=%b data=%h bp=%0d", s, ob_lat, ob_resp, ob_data, bp);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    for (int s = 0; s < 3; s++) begin
      arvalid[s] = 1'b0; rready[s] = 1'b0; araddr[s] = '0; arprot[s] = '0;
    end
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      total++;
      if (arready[s] !== 1'b0 || rvalid[s] !== 1'b0 || rdata[s] !== 32'h0 ||
          rresp[s] !== 2'b00 || rf_en[s] !== 1'b0 || rf_idx[s] !== 4'h0) begin
        bad++;
        $display("FAIL reset_values dut=%0d got arready=%b rvalid=%b rdata=%h rresp=%b en=%b idx=%h exp all zero",
                 s, arready[s], rvalid[s], rdata[s], rresp[s], rf_en[s], rf_idx[s]);
      end
    end
    aresetn = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      total++;
      if (arready[s] !== 1'b1) begin
        bad++;
        $display("FAIL reset_release_arready dut=%0d got=%b exp=1", s, arready[s]);
      end
    end
  endtask

  task automatic test_good_read();
    bit to;
    ar_send(0, 32'h8, 3'b000, to);
    collect(0, 0);
    total++;
    if (to || ob_to) begin
      bad++; $display("FAIL good_timeout got ar_to=%b r_to=%b exp 0,0", to, ob_to);
    end
    total++;
    if (ob_en !== 1 || ob_idx !== 4'd2) begin
      bad++; $display("FAIL good_rf_strobe got en_cycles=%0d idx=%0d exp 1,2", ob_en, ob_idx);
    end
    total++;
    if (ob_lat !== 3) begin
      bad++; $display("FAIL good_latency got=%0d exp=3", ob_lat);
    end
    total++;
    if (ob_data !== 32'hDEADBEEF || ob_resp !== 2'b00) begin
      bad++; $display("FAIL good_data got %h/%b exp deadbeef/00", ob_data, ob_resp);
    end
    total++;
    if (ob_rv_after !== 1'b0 || ob_arr_after !== 1'b1 || ob_data_after !== 32'h0 || ob_leak != 0) begin
      bad++; $display("FAIL good_complete got rvalid=%b arready=%b rdata=%h leak=%0d exp 0,1,0,0",
                      ob_rv_after, ob_arr_after, ob_data_after, ob_leak);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    ar_send(0, 32'h0, 3'b000, to);
    collect(0, 5);
    total++;
    if (to || ob_to || ob_data !== 32'h12345678 || ob_resp !== 2'b00) begin
      bad++; $display("FAIL bp_data got %h/%b to=%b exp 12345678/00", ob_data, ob_resp, to | ob_to);
    end
    total++;
    if (ob_unstable != 0 || ob_arr_bad != 0) begin
      bad++; $display("FAIL bp_stable got unstable=%0d arready_high=%0d exp 0,0", ob_unstable, ob_arr_bad);
    end
    total++;
    if (ob_rv_after !== 1'b0 || ob_arr_after !== 1'b1 || ob_resp_after !== 2'b00) begin
      bad++; $display("FAIL bp_complete got rvalid=%b arready=%b rresp=%b exp 0,1,00",
                      ob_rv_after, ob_arr_after, ob_resp_after);
    end
  endtask

  // Table-driven single reads checked against the model.
  task automatic test_table(input string name, input int s, input logic [31:0] addrs [], input logic [2:0] prots []);
    bit          to;
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    int          e_lat;
    for (int i = 0; i < addrs.size(); i++) begin
      model(s, addrs[i], prots[i], e_resp, e_data, e_lat);
      ar_send(s, addrs[i], prots[i], to);
      collect(s, 0);
      total++;
      if (to || ob_to || ob_resp !== e_resp || ob_data !== e_data || ob_lat !== e_lat) begin
        bad++;
        $display("FAIL %s addr=%h got resp=%b data=%h lat=%0d exp resp=%b data=%h lat=%0d",
                 name, addrs[i], ob_resp, ob_data, ob_lat, e_resp, e_data, e_lat);
      end
      total++;
      if (ob_en !== ((e_resp == 2'b00) ? 1 : 0)) begin
        bad++; $display("FAIL %s_rf_en addr=%h got strobes=%0d exp=%0d", name, addrs[i], ob_en, (e_resp == 2'b00) ? 1 : 0);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] a0 [] = '{32'h40, 32'h6, 32'hFFFF_FFFC};
    logic [2:0]  p0 [] = '{3'b000, 3'b000, 3'b001};
    logic [31:0] a1 [] = '{32'h8, 32'h8};
    logic [2:0]  p1 [] = '{3'b000, 3'b001};
    test_table("err_dut0", 0, a0, p0);
    test_table("err_priv", 1, a1, p1);
  endtask

  task automatic test_base();
    logic [31:0] a [] = '{32'h0FFC, 32'h1000, 32'h103C, 32'h1040};
    logic [2:0]  p [] = '{3'b000, 3'b000, 3'b000, 3'b000};
    test_table("base", 2, a, p);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h3C};
    int          hs_cyc [$];
    logic [31:0] got_d  [$];
    logic [1:0]  got_r  [$];
    int          n = 0;
    bit          hs, rhs;
    logic [31:0] d;
    logic [1:0]  r;
    rready[0]  = 1'b1;
    araddr[0]  = addrs[0];
    arprot[0]  = 3'b000;
    arvalid[0] = 1'b1;
    for (int t = 0; t < 40 && got_d.size() < 3; t++) begin
      hs  = arvalid[0] && arready[0];
      rhs = rvalid[0] && rready[0];
      d   = rdata[0];
      r   = rresp[0];
      tick();
      if (hs) begin
        hs_cyc.push_back(cyc);
        n++;
        if (n < 3) araddr[0] = addrs[n];
        else arvalid[0] = 1'b0;
      end
      if (rhs) begin
        got_d.push_back(d);
        got_r.push_back(r);
        $display("txn dut=0 b2b resp=%b data=%h", r, d);
      end
    end
    arvalid[0] = 1'b0;
    rready[0]  = 1'b0;
    total++;
    if (hs_cyc.size() != 3 || got_d.size() != 3) begin
      bad++; $display("FAIL b2b_count got hs=%0d resp=%0d exp 3,3", hs_cyc.size(), got_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_d[i] !== regs[addrs[i] >> 2] || got_r[i] !== 2'b00) begin
          bad++; $display("FAIL b2b_data%0d got %h/%b exp %h/00", i, got_d[i], got_r[i], regs[addrs[i] >> 2]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (hs_cyc[i] - hs_cyc[i-1] != 4) begin
          bad++; $display("FAIL b2b_spacing%0d got=%0d exp=4", i, hs_cyc[i] - hs_cyc[i-1]);
        end
      end
    end
  endtask

  // phase 0 aborts in WAIT, phase 1 aborts while the response is pending.
  task automatic test_reset_mid(input int phase);
    bit to;
    int stale = 0;
    rready[0] = 1'b0;
    ar_send(0, 32'h14, 3'b000, to);
    tick();
    if (phase == 1) tick();
    aresetn = 1'b0;
    tick();
    total++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0 || arready[0] !== 1'b0 || rf_en[0] !== 1'b0) begin
      bad++; $display("FAIL reset_mid%0d got rvalid=%b rdata=%h arready=%b en=%b exp 0,0,0,0",
                      phase, rvalid[0], rdata[0], arready[0], rf_en[0]);
    end
    tick();
    aresetn = 1'b1;
    tick();
    rready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rvalid[0]) stale++;
      tick();
    end
    rready[0] = 1'b0;
    total++;
    if (stale != 0 || to) begin
      bad++; $display("FAIL reset_mid%0d_stale got stale_cycles=%0d exp 0", phase, stale);
    end
    ar_send(0, 32'h18, 3'b000, to);
    collect(0, 0);
    total++;
    if (to || ob_to || ob_data !== regs[6] || ob_resp !== 2'b00) begin
      bad++; $display("FAIL reset_mid%0d_recover got %h/%b exp %h/00", phase, ob_data, ob_resp, regs[6]);
    end
  endtask

  task automatic test_random();
    bit          to;
    int          s, kind, bp, e_lat;
    logic [31:0] base, a;
    logic [2:0]  p;
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    for (int it = 0; it < 40; it++) begin
      s    = $urandom_range(0, 2);
      kind = $urandom_range(0, 3);
      bp   = $urandom_range(0, 3);
      base = (s == 2) ? 32'h1000 : 32'h0;
      case (kind)
        0:       a = base + 4 * $urandom_range(0, 15);
        1:       a = base + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
        2:       a = base + 64 + 4 * $urandom_range(0, 15);
        default: a = base - 4 * $urandom_range(1, 4);
      endcase
      p = 3'($urandom);
      model(s, a, p, e_resp, e_data, e_lat);
      ar_send(s, a, p, to);
      collect(s, bp);
      total++;
      if (to || ob_to || ob_resp !== e_resp || ob_data !== e_data || ob_lat !== e_lat ||
          ob_en !== ((e_resp == 2'b00) ? 1 : 0) || ob_unstable != 0 || ob_arr_bad != 0 ||
          ob_leak != 0 || ob_rv_after !== 1'b0 || ob_arr_after !== 1'b1) begin
        bad++;
        $display("FAIL rand%0d dut=%0d addr=%h prot=%b got resp=%b data=%h lat=%0d en=%0d unst=%0d arr=%0d leak=%0d exp resp=%b data=%h lat=%0d",
                 it, s, a, p, ob_resp, ob_data, ob_lat, ob_en, ob_unstable, ob_arr_bad, ob_leak, e_resp, e_data, e_lat);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[0] = 32'h12345678;
    regs[2] = 32'hDEADBEEF;
    test_reset();
    test_good_read();
    test_backpressure();
    test_errors();
    test_base();
    test_back_to_back();
    test_reset_mid(0);
    test_reset_mid(1);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
